// File: rtl/io_pkg.sv
// Shared constants for the IO responder: register address map, display
// blanking code and bus widths.
package io_pkg;

  typedef logic [11:0] io_addr_t;

  localparam io_addr_t ADDR_LED    = 12'hC60;
  localparam io_addr_t ADDR_SW     = 12'hC70;
  localparam io_addr_t ADDR_SEGVAL = 12'hC80;
  localparam io_addr_t ADDR_SEGEN  = 12'hC84;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int unsigned LED_W = 16;
  localparam int unsigned SW_W  = 16;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
//   nibble : 4-bit hex digit
//   seg    : segments {dp,g,f,e,d,c,b,a}, active-low, dp always off
module seg7_hex_decode (
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'hFF;
    unique case (nibble)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      4'hF: seg = 8'h8E;
    endcase
  end

endmodule

// File: rtl/io_responder.sv
// Peripheral-side responder for the CPU memory-mapped IO path.
// Holds the LED and seven-segment registers, scans the 8-digit display,
// and synchronises/debounces the board switches for readback.
//   clk, rst    : clock, asynchronous active-high reset
//   LEDCtrl     : write chip select
//   SwitchCtrl  : read chip select
//   addr        : byte address, addr[11:0] decoded
//   w_data      : write data
//   bdata       : combinational read data (16 bits)
//   led         : board LEDs
//   sw          : raw asynchronous switches
//   seg_an      : digit anodes, active-low
//   seg_ca      : segments {dp,g,f,e,d,c,b,a}, active-low
module io_responder
  import io_pkg::*;
#(
  parameter int unsigned DB_CNT   = 1000000,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              LEDCtrl,
  input  logic              SwitchCtrl,
  input  logic [31:0]       addr,
  input  logic [31:0]       w_data,
  output logic [15:0]       bdata,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   sw,
  output logic [7:0]        seg_an,
  output logic [7:0]        seg_ca
);

  localparam int unsigned DBW = $clog2(DB_CNT + 1);
  localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CNT - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  io_addr_t          reg_addr;
  logic              unused_addr_bits;

  logic [LED_W-1:0]  led_reg;
  logic [31:0]       seg_val;
  logic [7:0]        seg_en;

  logic [SW_W-1:0]   sw_s1;
  logic [SW_W-1:0]   sw_s2;
  logic [SW_W-1:0]   sw_stable;
  logic [DBW-1:0]    db_cnt;

  logic [SCW-1:0]    presc;
  logic [2:0]        dig;
  logic [3:0]        dig_nibble;
  logic [7:0]        dig_seg;

  assign reg_addr         = addr[11:0];
  assign unused_addr_bits = ^addr[31:12];

  // Register writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg <= '0;
      seg_val <= '0;
      seg_en  <= '0;
    end else if (LEDCtrl) begin
      unique case (reg_addr)
        ADDR_LED:    led_reg <= w_data[LED_W-1:0];
        ADDR_SEGVAL: seg_val <= w_data;
        ADDR_SEGEN:  seg_en  <= w_data[7:0];
        default:     ;
      endcase
    end
  end

  // Zero-latency read path; a simultaneous write to the same address is
  // seen here only after the edge.
  always_comb begin
    bdata = '0;
    if (SwitchCtrl) begin
      if (reg_addr == ADDR_SW)
        bdata = sw_stable;
      else if (reg_addr == ADDR_LED)
        bdata = led_reg;
    end
  end

  assign led = led_reg;

  // Switch synchroniser and whole-vector debouncer. The counter keeps
  // running through further changes as long as sw_s2 differs from the
  // accepted value; whatever sw_s2 holds at terminal count is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      sw_stable <= '0;
      db_cnt    <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      if (sw_s2 == sw_stable) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        sw_stable <= sw_s2;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Display scan prescaler and digit index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      dig   <= '0;
    end else if (presc == SCAN_LAST) begin
      presc <= '0;
      dig   <= dig + 3'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign dig_nibble = seg_val[{dig, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nibble (dig_nibble),
    .seg    (dig_seg)
  );

  // Registered display outputs, one cycle behind dig
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_an <= SEG_BLANK;
      seg_ca <= SEG_BLANK;
    end else if (seg_en[dig]) begin
      seg_an <= ~(8'd1 << dig);
      seg_ca <= dig_seg;
    end else begin
      seg_an <= SEG_BLANK;
      seg_ca <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed self-checking bench for io_responder (DB_CNT=4, SCAN_DIV=2).
module tb_io_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        LEDCtrl = 1'b0;
  logic        SwitchCtrl = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] w_data = '0;
  logic [15:0] bdata;
  logic [15:0] led;
  logic [15:0] sw = '0;
  logic [7:0]  seg_an;
  logic [7:0]  seg_ca;

  int unsigned tests = 0;
  int unsigned fails = 0;

  io_responder #(.DB_CNT(4), .SCAN_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .LEDCtrl    (LEDCtrl),
    .SwitchCtrl (SwitchCtrl),
    .addr       (addr),
    .w_data     (w_data),
    .bdata      (bdata),
    .led        (led),
    .sw         (sw),
    .seg_an     (seg_an),
    .seg_ca     (seg_ca)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  exp_an;
    logic [7:0]  exp_ca;
    int unsigned slot;
    int unsigned budget;

    tick();
    tick();

    // Reset mid-clock: outputs clear without waiting for an edge
    #2;
    rst = 1'b1;
    SwitchCtrl = 1'b1;
    addr = 32'h0000_0C70;
    #1;
    chk("rst_led", led, 16'h0000);
    chk("rst_seg_an", {8'h00, seg_an}, 16'h00FF);
    chk("rst_seg_ca", {8'h00, seg_ca}, 16'h00FF);
    chk("rst_bdata", bdata, 16'h0000);
    tick();
    rst = 1'b0;
    tick();

    // LED write and readback
    SwitchCtrl = 1'b0;
    LEDCtrl = 1'b1;
    addr = 32'h0000_0C60;
    w_data = 32'hDEAD_A5A5;
    tick();
    chk("led_write", led, 16'hA5A5);
    addr = 32'h0000_0C64;
    w_data = 32'h0000_1111;
    tick();
    chk("led_unmapped_write", led, 16'hA5A5);
    addr = 32'h0000_0C70;
    tick();
    chk("led_sw_reg_write", led, 16'hA5A5);
    LEDCtrl = 1'b0;
    SwitchCtrl = 1'b1;
    addr = 32'h0000_0C60;
    #1;
    chk("led_readback", bdata, 16'hA5A5);

    // Read and write on the same address in one cycle
    LEDCtrl = 1'b1;
    w_data = 32'h0000_1234;
    #1;
    chk("rw_pre_edge", bdata, 16'hA5A5);
    tick();
    chk("rw_post_edge", bdata, 16'h1234);
    LEDCtrl = 1'b0;
    addr = 32'h0000_0C84;
    #1;
    chk("read_unmapped", bdata, 16'h0000);

    // Debounce accept: 2 sync + 4 stable cycles
    addr = 32'h0000_0C70;
    sw = 16'h00F0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("db_accept_c%0d", k), bdata, (k < 6) ? 16'h0000 : 16'h00F0);
    end

    // Debounce bounce from a clean zero state
    pulse_reset();
    sw = 16'h0000;
    tick();
    for (int k = 0; k < 20; k++) begin
      sw = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      tick();
      chk($sformatf("db_bounce_c%0d", k), bdata, 16'h0000);
    end
    sw = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("db_bounce_tail_c%0d", k), bdata, 16'h0000);
    end

    // Display scan
    LEDCtrl = 1'b1;
    addr = 32'h0000_0C80;
    w_data = 32'h0000_00A3;
    tick();
    addr = 32'h0000_0C84;
    w_data = 32'hFFFF_FF03;
    tick();
    LEDCtrl = 1'b0;
    addr = 32'h0000_0C70;
    budget = 0;
    while (seg_an !== 8'hFF && budget < 40) begin
      tick();
      budget++;
    end
    while (seg_an !== 8'hFE && budget < 80) begin
      tick();
      budget++;
    end
    tests++;
    assert (budget < 80) else begin
      fails++;
      $error("FAIL scan_sync: observed budget %0d expected < 80", budget);
    end
    for (int i = 0; i < 32; i++) begin
      slot = (i / 2) % 8;
      if (slot == 0) begin
        exp_an = 8'hFE;
        exp_ca = 8'hB0;
      end else if (slot == 1) begin
        exp_an = 8'hFD;
        exp_ca = 8'h88;
      end else begin
        exp_an = 8'hFF;
        exp_ca = 8'hFF;
      end
      chk($sformatf("scan_an_%0d", i), {8'h00, seg_an}, {8'h00, exp_an});
      chk($sformatf("scan_ca_%0d", i), {8'h00, seg_ca}, {8'h00, exp_ca});
      tick();
    end

    // Reset mid-debounce discards the pending change
    sw = 16'hFFFF;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("db_rst_during", bdata, 16'h0000);
    chk("db_rst_seg_an", {8'h00, seg_an}, 16'h00FF);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("db_rst_c%0d", k), bdata, (k < 6) ? 16'h0000 : 16'hFFFF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
